// File: rtl/axi_full_burst_master.sv
// axi_full_burst_master: turns one (addr, beats, dir) command into AXI4 INCR bursts split at MAX_BURST and 4 KB pages
module axi_full_burst_master #(
  parameter int AXI_WIDTH_ID   = 4,
  parameter int AXI_WIDTH_ADDR = 32,
  parameter int AXI_WIDTH_DATA = 32,
  parameter int MAX_BURST      = 16,
  parameter int AXI_ID         = 0
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_WIDTH_ADDR-1:0]   cmd_addr,
  input  logic [15:0]                 cmd_beats,
  input  logic [AXI_WIDTH_DATA-1:0]   wd_data,
  input  logic [AXI_WIDTH_DATA/8-1:0] wd_strb,
  input  logic                        wd_valid,
  output logic                        wd_ready,
  output logic [AXI_WIDTH_DATA-1:0]   rd_data,
  output logic                        rd_last,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        done_err,
  output logic [AXI_WIDTH_ID-1:0]     m_axi_awid,
  output logic [AXI_WIDTH_ADDR-1:0]   m_axi_awaddr,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic                        m_axi_awlock,
  output logic [3:0]                  m_axi_awcache,
  output logic [2:0]                  m_axi_awprot,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_WIDTH_DATA-1:0]   m_axi_wdata,
  output logic [AXI_WIDTH_DATA/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [AXI_WIDTH_ID-1:0]     m_axi_bid,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [AXI_WIDTH_ID-1:0]     m_axi_arid,
  output logic [AXI_WIDTH_ADDR-1:0]   m_axi_araddr,
  output logic [7:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  output logic                        m_axi_arlock,
  output logic [3:0]                  m_axi_arcache,
  output logic [2:0]                  m_axi_arprot,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [AXI_WIDTH_ID-1:0]     m_axi_rid,
  input  logic [AXI_WIDTH_DATA-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rlast,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);
  localparam int AW = AXI_WIDTH_ADDR;
  localparam int SZ = $clog2(AXI_WIDTH_DATA / 8);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRESP, RDATA, DONE} state_t;

  state_t          state;
  logic            write, err, awvalid, arvalid;
  logic [AW-1:0]   addr, ax_addr;
  logic [15:0]     remaining;
  logic [8:0]      n, cnt, n_next;
  logic [7:0]      ax_len;
  logic [16:0]     lim, pg;
  logic            last_beat, w_hs, r_hs, unused_bits;

  // beats left before the 4 KB page ends, in data-width units
  assign pg        = 17'((13'h1000 - {1'b0, addr[11:0]}) >> SZ);
  assign lim       = {1'b0, remaining} < 17'(MAX_BURST) ? {1'b0, remaining} : 17'(MAX_BURST);
  assign n_next    = 9'(lim < pg ? lim : pg);
  assign last_beat = cnt == n - 9'd1;
  assign w_hs      = m_axi_wvalid && m_axi_wready;
  assign r_hs      = state == RDATA && m_axi_rvalid && rd_ready;

  assign cmd_ready    = state == IDLE && !done;
  assign wd_ready     = state == WDATA && m_axi_wready;
  assign m_axi_wvalid = state == WDATA && wd_valid;
  assign m_axi_wdata  = wd_data;
  assign m_axi_wstrb  = wd_strb;
  assign m_axi_wlast  = state == WDATA && last_beat;
  assign m_axi_bready = state == WRESP;
  assign rd_valid     = state == RDATA && m_axi_rvalid;
  assign rd_data      = m_axi_rdata;
  assign rd_last      = state == RDATA && last_beat && remaining == '0;
  assign m_axi_rready = state == RDATA && rd_ready;

  assign m_axi_awid    = AXI_WIDTH_ID'(AXI_ID);
  assign m_axi_awaddr  = ax_addr;
  assign m_axi_awlen   = ax_len;
  assign m_axi_awsize  = 3'(SZ);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid;
  assign m_axi_arid    = AXI_WIDTH_ID'(AXI_ID);
  assign m_axi_araddr  = ax_addr;
  assign m_axi_arlen   = ax_len;
  assign m_axi_arsize  = 3'(SZ);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid;

  assign unused_bits = ^{m_axi_bid, m_axi_rid, cmd_addr[SZ-1:0]};

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      write     <= 1'b0;
      err       <= 1'b0;
      awvalid   <= 1'b0;
      arvalid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_err  <= 1'b0;
      addr      <= '0;
      ax_addr   <= '0;
      ax_len    <= '0;
      remaining <= '0;
      n         <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (cmd_valid && cmd_ready) begin
          write     <= cmd_write;
          addr      <= {cmd_addr[AW-1:SZ], {SZ{1'b0}}};
          remaining <= cmd_beats;
          busy      <= 1'b1;
          err       <= 1'b0;
          state     <= cmd_beats == '0 ? DONE : ADDR;
        end
        ADDR: if (!awvalid && !arvalid) begin
          n       <= n_next;
          ax_addr <= addr;
          ax_len  <= 8'(n_next - 9'd1);
          awvalid <= write;
          arvalid <= !write;
        end else if ((awvalid && m_axi_awready) || (arvalid && m_axi_arready)) begin
          awvalid   <= 1'b0;
          arvalid   <= 1'b0;
          cnt       <= '0;
          addr      <= addr + (AW'(n) << SZ);
          remaining <= remaining - 16'(n);
          state     <= write ? WDATA : RDATA;
        end
        WDATA: if (w_hs) begin
          cnt <= cnt + 9'd1;
          if (last_beat) state <= WRESP;
        end
        WRESP: if (m_axi_bvalid) begin
          err   <= err | (m_axi_bresp != 2'b00);
          state <= remaining != '0 ? ADDR : DONE;
        end
        // slave rlast is only cross-checked; our own beat count ends the burst
        RDATA: if (r_hs) begin
          cnt <= cnt + 9'd1;
          err <= err | (m_axi_rresp != 2'b00) | (m_axi_rlast != last_beat);
          if (last_beat) state <= remaining != '0 ? ADDR : DONE;
        end
        DONE: begin
          done     <= 1'b1;
          done_err <= err;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/axi_full_burst_master.md
Name: axi_full_burst_master

Overview:
Command-driven AXI4-Full master engine that turns one (address, beat-count, direction) command into a sequence of legal INCR bursts. Bursts are split at MAX_BURST beats and at 4 KB boundaries. Write data enters through a valid/ready stream and read data leaves through one. It is the synthesizable, parametrised successor to the cosim BFM master and sits in front of the AXI interconnect in benches and SoC DMA paths.

Parameters:
AXI_WIDTH_ID, 4, ID width
AXI_WIDTH_ADDR, 32, address width
AXI_WIDTH_DATA, 32, data width; legal values 32, 64, 128
MAX_BURST, 16, max beats per AXI burst; power of 2, 1..256
AXI_ID, 0, constant value driven on AWID/ARID

Ports:
aclk  in  1  clock; all logic on rising edge
aresetn  in  1  synchronous active-low reset
cmd_valid/cmd_ready  in/out  1/1  command handshake
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  AXI_WIDTH_ADDR  start byte address; low log2(DATA/8) bits forced to 0
cmd_beats  in  16  total beats; 0 = null command
wd_data/wd_strb/wd_valid/wd_ready  in/in/in/out  DATA/DATA/8/1/1  write data stream
rd_data/rd_last/rd_valid/rd_ready  out/out/out/in  DATA/1/1/1  read data stream
busy  out  1  high from command accept until done
done  out  1  one-cycle pulse at command completion
done_err  out  1  valid with done; 1 if any BRESP/RRESP != OKAY
m_axi_aw{id,addr,len,size,burst,lock,cache,prot,valid}/awready  out/in  AXI4 write address channel
m_axi_w{data,strb,last,valid}/wready  out/in  write data channel
m_axi_b{id,resp,valid}/bready  in/out  write response channel
m_axi_ar{id,addr,len,size,burst,lock,cache,prot,valid}/arready  out/in  read address channel
m_axi_r{id,data,resp,last,valid}/rready  in/out  read data channel

Behaviour:
- Reset (aresetn sampled low): state IDLE; all AXI valids/readies 0; cmd_ready 1; wd_ready, rd_valid, rd_last, busy, done, done_err 0; error accumulator cleared.
- Reset mid-transfer: applied on the next edge; the burst is abandoned without completion.
- Fixed AXI fields:
  - AxSIZE = log2(DATA/8); AxBURST = 2'b01 (INCR); AxLOCK = 0; AxCACHE = 4'b0011; AxPROT = 3'b000; AxID = AXI_ID.
- States: IDLE, ADDR, WDATA, WRESP, RDATA, DONE.
- IDLE:
  - cmd_ready = 1. On cmd_valid, latch addr, beats and direction, set busy, clear error accumulator.
  - beats = 0: go to DONE.
  - Otherwise: go to ADDR.
- ADDR: computes burst beats n = min(remaining, MAX_BURST, (4096 - addr[11:0]) / (DATA/8)).
  - AxLEN = n-1; AWVALID or ARVALID is asserted the cycle after entry.
  - AxADDR and AxLEN are held stable until the handshake.
  - After the handshake go to WDATA (write) or RDATA (read).
- WDATA:
  - Combinational passthrough: wvalid = wd_valid, wd_ready = wready, wdata/wstrb = wd_*.
  - wlast = 1 on beat n of the current burst.
  - After the wlast handshake go to WRESP.
- WRESP:
  - bready = 1. On bvalid, OR (bresp != 0) into the error accumulator.
  - If beats remain: addr += n*DATA/8 (mod 2^AXI_WIDTH_ADDR), go to ADDR.
  - Otherwise: go to DONE.
- RDATA:
  - Combinational passthrough: rd_valid = rvalid, rready = rd_ready, rd_data = rdata.
  - Each beat ORs (rresp != 0) into the error accumulator.
  - rd_last = 1 only on the final beat of the whole command, not per burst.
  - If rlast arrives early or late relative to n, set error; the beat count governs the exit.
  - At end of burst: go to ADDR if beats remain, else DONE.
- DONE:
  - done = 1 for one cycle; done_err = accumulator; busy drops.
  - Next state IDLE; a new command is accepted no earlier than the cycle after done.
- Ordering: only one burst outstanding; next AxVALID is asserted the cycle after the previous B handshake or final R beat.
- Slave errors do not abort; the command always runs to its full beat count.

Test Plan:
1. DATA=32, MAX_BURST=16, write 4 beats @0x1000, OKAY -> one AW addr=0x1000 len=3 size=2; wlast on 4th beat; done=1, done_err=0.
2. Read 8 beats @0x0FF0, DATA=32 -> AR 0x0FF0 len=3, then AR 0x1000 len=3; rd_last only on 8th beat; done_err=0.
3. Write 40 beats @0x0, MAX_BURST=16 -> AW lens 15, 15, 7 at addrs 0x0, 0x40, 0x80; three B handshakes, then done.
4. Write 32 beats with SLVERR on the second B -> both bursts complete; done_err=1. The next command's OKAY run gives done_err=0.
5. cmd_beats=0 -> no AXI valid ever asserted; done pulses 2 cycles after accept, done_err=0.
6. aresetn low mid-WDATA, beat 3 of 8 -> next cycle wvalid=awvalid=0, busy=0, cmd_ready=1. A new command then runs normally.
7. DATA=128, random wready/rvalid/rd_ready backpressure -> data stream matches the memory model bit-exact; no protocol violation.
